rb1_reverse_ctrl: RTL and testbench



---
 rtl/rb1_reverse_ctrl.sv | 140 ++++++++++++++
 tb/tb_rb1_reverse_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rb1_reverse_ctrl.sv
// Frame controller in front of the 18x8 single-port RAM RB1: loads one frame of
// bytes into addresses 0..WORD_DEPTH-1, then streams them back out in reverse order.
module rb1_reverse_ctrl #(
    parameter int WORD_WIDTH = 8,
    parameter int WORD_DEPTH = 18,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [WORD_WIDTH-1:0] IN_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [WORD_WIDTH-1:0] OUT_DATA,
    output logic                  DONE,
    output logic [ADDR_WIDTH-1:0] RAM_A,
    output logic [WORD_WIDTH-1:0] RAM_D,
    output logic                  RAM_WENn,
    input  logic [WORD_WIDTH-1:0] RAM_Q
);

    // state      | meaning
    // S_IDLE     | one cycle after reset, raises IN_READY
    // S_LOAD     | accepting bytes, writing RAM at wr_cnt
    // S_RD_ISSUE | read address rd_ptr presented, RAM captures Q on this edge
    // S_RD_WAIT  | RAM_Q valid, copied into the output register
    // S_OUT      | OUT_VALID held until the downstream handshake
    // S_DONE     | DONE pulse, re-arms input for the next frame
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

    state_t                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;

    logic in_hs;
    logic out_hs;

    assign in_hs  = (state_q == S_LOAD) && IN_VALID && in_ready_q;
    assign out_hs = (state_q == S_OUT) && out_valid_q && OUT_READY;

    assign RAM_D    = IN_DATA;
    assign RAM_A    = (state_q == S_LOAD) ? wr_cnt_q : rd_ptr_q;
    assign RAM_WENn = ~in_hs;

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign DONE      = done_q;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        wr_cnt_d    = wr_cnt_q;
        rd_ptr_d    = rd_ptr_q;

        unique case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                if (in_hs) begin
                    if (wr_cnt_q == LAST_ADDR) begin
                        in_ready_d = 1'b0;
                        wr_cnt_d   = '0;
                        rd_ptr_d   = LAST_ADDR;
                        state_d    = S_RD_ISSUE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                out_data_d  = RAM_Q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    if (rd_ptr_q == '0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q - 1'b1;
                        state_d  = S_RD_ISSUE;
                    end
                end
            end
            S_DONE: begin
                in_ready_d = 1'b1;
                state_d    = S_LOAD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_rb1_reverse_ctrl.sv
// Bench for rb1_reverse_ctrl: behavioural RB1 RAM plus a frame-level LIFO reference.
module tb_rb1_reverse_ctrl;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] IN_DATA = 8'h00;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic [7:0] OUT_DATA;
    logic       DONE;
    logic [4:0] RAM_A;
    logic [7:0] RAM_D;
    logic       RAM_WENn;
    logic [7:0] RAM_Q;

    rb1_reverse_ctrl #(.WORD_WIDTH(8), .WORD_DEPTH(18), .ADDR_WIDTH(5)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .DONE(DONE), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_WENn(RAM_WENn), .RAM_Q(RAM_Q)
    );

    always #5 CLK = ~CLK;

    // RB1 model: write when WENn=0, otherwise registered read.
    logic [7:0] mem [0:17];
    logic [7:0] ram_q_r = 8'h00;
    initial for (int i = 0; i < 18; i++) mem[i] = 8'hEE;
    always @(posedge CLK) begin
        if (RAM_A < 5'd18) begin
            if (!RAM_WENn) mem[RAM_A] <= RAM_D;
            else           ram_q_r    <= mem[RAM_A];
        end else begin
            ram_q_r <= 8'hXX;
        end
    end
    assign RAM_Q = ram_q_r;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model state, expressed in window numbers (window w ends at posedge P_w).
    logic [7:0] src_q[$];
    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];
    int  w = 0;
    int  valid_due = -1;
    int  done_due = -1;
    int  ready_from = 0;
    bit  loading = 1'b1;
    bit  exp_valid = 1'b0;
    int  frames_done = 0;
    int  in_mode = 0;
    int  out_mode = 0;
    logic [7:0] stall_byte = 8'h00;
    int  stall_left = 0;
    bit  prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic cycle();
        logic [7:0] e;
        @(negedge CLK);
        if (w == valid_due) exp_valid = 1'b1;
        case (in_mode)
            0: IN_VALID = (src_q.size() > 0);
            1: IN_VALID = (src_q.size() > 0) && (w % 2 == 0);
            default: IN_VALID = (src_q.size() > 0) && ($urandom_range(0, 2) != 0);
        endcase
        IN_DATA = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
        if (exp_valid && exp_q.size() > 0 && exp_q[0] == stall_byte && stall_left > 0) begin
            OUT_READY = 1'b0;
            stall_left--;
        end else begin
            OUT_READY = (out_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        #1;
        chk("in_ready", IN_READY, loading && (w >= ready_from));
        chk("out_valid", OUT_VALID, exp_valid);
        chk("done", DONE, w == done_due);
        chk("ram_wenn", RAM_WENn, !(IN_VALID && IN_READY));
        if (prev_stall) chk("hold_data", OUT_DATA, prev_data);
        prev_stall = OUT_VALID && !OUT_READY;
        prev_data  = OUT_DATA;
        if (IN_VALID && IN_READY) begin
            chk("ram_a_wr", RAM_A, frame_q.size());
            chk("ram_d", RAM_D, IN_DATA);
            frame_q.push_back(IN_DATA);
            void'(src_q.pop_front());
            if (frame_q.size() == 18) begin
                for (int i = 17; i >= 0; i--) exp_q.push_back(frame_q[i]);
                frame_q.delete();
                loading   = 1'b0;
                valid_due = w + 3;
            end
        end
        if (OUT_VALID && OUT_READY && exp_valid) begin
            if (exp_q.size() == 0) begin
                chk("out_extra", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", OUT_DATA, e);
            end
            exp_valid = 1'b0;
            if (exp_q.size() == 0) begin
                done_due   = w + 1;
                ready_from = w + 2;
                loading    = 1'b1;
                frames_done++;
            end else begin
                valid_due = w + 3;
            end
        end
        w++;
    endtask

    task automatic load_frame(input int kind, input logic [7:0] base);
        for (int i = 0; i < 18; i++)
            src_q.push_back(kind == 0 ? 8'(base + i) : 8'($urandom));
    endtask

    task automatic run_until_done();
        int target = frames_done + 1;
        int budget = 0;
        while (!(frames_done == target && w > done_due + 1)) begin
            cycle();
            budget++;
            if (budget > 2000) begin
                chk("frame_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        RESETn   = 1'b0;
        IN_VALID = 1'b1;
        #1;
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_data", OUT_DATA, 0);
        chk("rst_done", DONE, 0);
        chk("rst_wenn", RAM_WENn, 1);
        chk("rst_ram_a", RAM_A, 0);
        src_q.delete(); frame_q.delete(); exp_q.delete();
        exp_valid = 1'b0; valid_due = -1; done_due = -1;
        loading = 1'b1; prev_stall = 1'b0; stall_left = 0;
        repeat (n) @(negedge CLK);
        chk("rst_hold_ready", IN_READY, 0);
        RESETn   = 1'b1;
        IN_VALID = 1'b0;
        #1;
        chk("rel_in_ready", IN_READY, 0);
        ready_from = w;
    endtask

    initial begin
        int budget;
        do_reset(3);

        // incrementing frame, no gaps, downstream always ready, with a 5-cycle stall on 0x0C
        in_mode = 0; out_mode = 0; stall_byte = 8'h0C; stall_left = 5;
        load_frame(0, 8'h01);
        run_until_done();
        chk("stall_used", stall_left, 0);

        // gapped input
        in_mode = 1; out_mode = 0;
        load_frame(0, 8'h40);
        run_until_done();

        // reset after 7 output handshakes, then a fresh frame
        in_mode = 0; out_mode = 0;
        load_frame(0, 8'h01);
        budget = 0;
        while (!(loading == 1'b0 && exp_q.size() == 11) && budget < 500) begin
            cycle();
            budget++;
        end
        chk("mid_reset_reach", budget < 500, 1);
        do_reset(2);
        load_frame(0, 8'h80);
        run_until_done();

        // back-to-back frames
        load_frame(0, 8'h01);
        run_until_done();
        load_frame(0, 8'hA0);
        run_until_done();

        // random data, random valid and ready
        in_mode = 2; out_mode = 1;
        for (int f = 0; f < 4; f++) begin
            load_frame(1, 8'h00);
            run_until_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
